// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the multi-port register file
package regfile_pkg;
    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write/alloc bus of the register file; master drives addresses, slave returns data
// Ports: rd_addr/rd_data/rd_busy per read port, wr_en/wr_addr/wr_data per write port,
// alloc_en/alloc_addr for the scoreboard, ready after the clear sweep, rd_perr with REGFILE_PARITY_EN.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NREGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    localparam int AW      = $clog2(NUM_REGS)
);
    logic                           ready;
    logic [NUM_RD-1:0][AW-1:0]      rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]    rd_data;
    logic [NUM_RD-1:0]              rd_busy;
    logic [NUM_WR-1:0]              wr_en;
    logic [NUM_WR-1:0][AW-1:0]      wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0]    wr_data;
    logic                           alloc_en;
    logic [AW-1:0]                  alloc_addr;
`ifdef REGFILE_PARITY_EN
    logic [NUM_RD-1:0]              rd_perr;
    modport master (output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
                    input ready, rd_data, rd_busy, rd_perr);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
                    output ready, rd_data, rd_busy, rd_perr);
`else
    modport master (output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
                    input ready, rd_data, rd_busy);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
                    output ready, rd_data, rd_busy);
`endif
endinterface

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: per-register write winner across write ports, highest-index port wins
// Ports: wr_en/wr_addr/wr_data in per write port; hit/data out per register.
module regfile_wr_arb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_WR   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]         wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]       wr_data,
    output logic [NUM_REGS-1:0]               hit,
    output logic [NUM_REGS-1:0][XLEN-1:0]     data
);
    always_comb begin
        hit  = '0;
        data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                hit[wr_addr[p]]  = 1'b1;
                data[wr_addr[p]] = wr_data[p];
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD-read / NUM_WR-write register file with bypass, busy scoreboard and post-reset clear sweep
// Ports: clk, rst (sync, active-high), bus (regfile_if.slave). Optional parity: REGFILE_PARITY_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NREGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    rf_state_e                       state;
    logic [AW-1:0]                   clr_idx;
    logic [XLEN-1:0]                 regs [NUM_REGS];
    logic [NUM_REGS-1:0]             busy, hit, alloc_mask;
    logic [NUM_REGS-1:0][XLEN-1:0]   wdat;
    logic [NUM_WR-1:0]               wen;
    logic                            run;
`ifdef REGFILE_PARITY_EN
    logic [NUM_REGS-1:0]             par;
`endif
    assign run        = state == RF_RUN;
    assign bus.ready  = run;
    assign wen        = run ? bus.wr_en : '0;
    assign alloc_mask = (run && bus.alloc_en && bus.alloc_addr != '0) ? NUM_REGS'(1) << bus.alloc_addr : '0;
    regfile_wr_arb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR)) u_arb (
        .wr_en   (wen),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .hit     (hit),
        .data    (wdat)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_INIT;
            clr_idx <= '0;
            busy    <= '0;
        end else if (state == RF_INIT) begin
            regs[clr_idx] <= '0;
`ifdef REGFILE_PARITY_EN
            par[clr_idx]  <= 1'b0;
`endif
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(NUM_REGS - 1)) state <= RF_RUN;
        end else begin
            for (int a = 1; a < NUM_REGS; a++) begin
                if (hit[a]) begin
                    regs[a] <= wdat[a];
`ifdef REGFILE_PARITY_EN
                    par[a]  <= ^wdat[a];
`endif
                end
            end
            // alloc is ORed after the clear so a colliding new producer keeps the entry busy
            busy <= (busy & ~hit) | alloc_mask;
        end
    end
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i] = (run && bus.rd_addr[i] != '0) ?
                             (hit[bus.rd_addr[i]] ? wdat[bus.rd_addr[i]] : regs[bus.rd_addr[i]]) : '0;
            bus.rd_busy[i] = run && bus.rd_addr[i] != '0 && busy[bus.rd_addr[i]] && !hit[bus.rd_addr[i]];
`ifdef REGFILE_PARITY_EN
            bus.rd_perr[i] = run && bus.rd_addr[i] != '0 && !hit[bus.rd_addr[i]] &&
                             ((^regs[bus.rd_addr[i]]) != par[bus.rd_addr[i]]);
`endif
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of sweep, bypass, reg0, write priority, scoreboard and reset-in-run
module tb_regfile_mp;
    localparam int XLEN = 32, NUM_REGS = 32, NUM_RD = 2, NUM_WR = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    regfile_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();
    regfile_mp #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(negedge clk);
    endtask
    task automatic idle();
        bus.wr_en = '0;
        bus.alloc_en = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.alloc_en = 1'b0; bus.alloc_addr = '0;
        repeat (3) cyc();
        #1 chk("ready_reset", bus.ready, 0);
        rst = 1'b0;
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'h55;
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd5; bus.rd_addr[0] = 5'd5;
        #1 chk("init_rd_data", bus.rd_data[0], 0);
        chk("init_rd_busy", bus.rd_busy[0], 0);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            #1 chk("ready_sweep", bus.ready, (k == 32) ? 1 : 0);
            if (k == 31) idle();
        end
        chk("init_wr_ignored", bus.rd_data[0], 0);
        chk("init_alloc_ignored", bus.rd_busy[0], 0);
        for (int a = 0; a < NUM_REGS; a++) begin
            bus.rd_addr[0] = 5'(a); bus.rd_addr[1] = 5'(31 - a);
            #1 chk("clear_p0", bus.rd_data[0], 0);
            chk("clear_p1", bus.rd_data[1], 0);
        end
        cyc();
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'hDEADBEEF; bus.rd_addr[1] = 5'd7;
        #1 chk("bypass_same", bus.rd_data[1], 32'hDEADBEEF);
        cyc(); idle();
        #1 chk("bypass_stored", bus.rd_data[1], 32'hDEADBEEF);
        cyc();
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd0; bus.wr_data[0] = 32'h1234;
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0; bus.rd_addr[0] = 5'd0;
        #1 chk("r0_data_same", bus.rd_data[0], 0);
        chk("r0_busy_same", bus.rd_busy[0], 0);
        cyc(); idle();
        #1 chk("r0_data_next", bus.rd_data[0], 0);
        chk("r0_busy_next", bus.rd_busy[0], 0);
        cyc();
        bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd3; bus.wr_data[0] = 32'hAAAA;
        bus.wr_addr[1] = 5'd3; bus.wr_data[1] = 32'h5555; bus.rd_addr[0] = 5'd3;
        #1 chk("prio_bypass", bus.rd_data[0], 32'h5555);
        cyc(); idle();
        #1 chk("prio_stored", bus.rd_data[0], 32'h5555);
        cyc();
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9; bus.rd_addr[0] = 5'd9; bus.rd_addr[1] = 5'd9;
        #1 chk("alloc_same", bus.rd_busy[0], 0);
        cyc(); idle();
        #1 chk("alloc_next_p0", bus.rd_busy[0], 1);
        chk("alloc_next_p1", bus.rd_busy[1], 1);
        bus.wr_en = 2'b10; bus.wr_addr[1] = 5'd9; bus.wr_data[1] = 32'h99;
        #1 chk("wr_mask_busy", bus.rd_busy[0], 0);
        chk("wr_mask_data", bus.rd_data[0], 32'h99);
        cyc(); idle();
        #1 chk("wr_clear_busy", bus.rd_busy[0], 0);
        chk("wr_clear_data", bus.rd_data[1], 32'h99);
        bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'h1999;
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
        #1 chk("collide_same", bus.rd_busy[0], 0);
        cyc(); idle();
        #1 chk("collide_busy", bus.rd_busy[0], 1);
        chk("collide_data", bus.rd_data[0], 32'h1999);
`ifdef REGFILE_PARITY_EN
        begin
            logic [NUM_REGS-1:0] pv;
            bus.rd_addr[0] = 5'd7; bus.rd_addr[1] = 5'd0;
            #1 chk("perr_clean", bus.rd_perr[0], 0);
            pv = dut.par;
            force dut.par = pv ^ (NUM_REGS'(1) << 7);
            #1 chk("perr_flip", bus.rd_perr[0], 1);
            chk("perr_r0", bus.rd_perr[1], 0);
            release dut.par;
        end
`endif
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.rd_addr[0] = 5'd7; bus.rd_addr[1] = 5'd9;
        #1 chk("rerst_ready", bus.ready, 0);
        chk("rerst_busy", bus.rd_busy[1], 0);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            #1 chk("ready_resweep", bus.ready, (k == 32) ? 1 : 0);
        end
        chk("rerst_r7", bus.rd_data[0], 0);
        chk("rerst_r9", bus.rd_data[1], 0);
        chk("rerst_busy9", bus.rd_busy[1], 0);
        bus.rd_addr[0] = 5'd3;
        #1 chk("rerst_r3", bus.rd_data[0], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
